// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the unified memory port arbiter
// Contents: FSM state encoding, requester IDs, default data/address widths.
package mem_arb_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_ADDRSIZE = 12;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

    // Requester IDs double as bit positions in the one-hot grant vector.
    typedef logic [1:0] port_id_t;
    localparam port_id_t ID_LD   = 2'd0;
    localparam port_id_t ID_D    = 2'd1;
    localparam port_id_t ID_IF   = 2'd2;
    localparam port_id_t ID_NONE = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signals of the port arbiter
// Groups: fetch port (if_*), data port (d_*), loader port (ld_*),
//         memory side (mem_*), and the busy status.
// Modports: slave = the arbiter, master = requesters plus memory model.
interface mem_port_arbiter_if #(
    parameter int WIDTH    = mem_arb_pkg::DEF_WIDTH,
    parameter int ADDRSIZE = mem_arb_pkg::DEF_ADDRSIZE
) ();

    logic                if_req;
    logic [ADDRSIZE-1:0] if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [WIDTH-1:0]    if_rdata;

    logic                d_req;
    logic                d_we;
    logic [ADDRSIZE-1:0] d_addr;
    logic [WIDTH-1:0]    d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [WIDTH-1:0]    d_rdata;

    logic                ld_req;
    logic                ld_we;
    logic [ADDRSIZE-1:0] ld_addr;
    logic [WIDTH-1:0]    ld_wdata;
    logic                ld_gnt;
    logic                ld_rvalid;
    logic [WIDTH-1:0]    ld_rdata;

    logic                mem_en;
    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;

    logic                busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fixed-priority selector with fetch starvation guard
// Ports: clk, rst (async active-low), arb_en (arbitration allowed this cycle),
//        ld_req/d_req/if_req (requests), gnt (one-hot, indexed by requester ID).
module mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       ld_req,
    input  logic       d_req,
    input  logic       if_req,
    output logic [2:0] gnt
);
    import mem_arb_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == SW'(STARVE_MAX));

    // Loader always wins; a starved fetch jumps ahead of the data port only.
    always_comb begin
        gnt = 3'b000;
        if (arb_en) begin
            if (ld_req)
                gnt[ID_LD] = 1'b1;
            else if (if_req && starved)
                gnt[ID_IF] = 1'b1;
            else if (d_req)
                gnt[ID_D] = 1'b1;
            else if (if_req)
                gnt[ID_IF] = 1'b1;
        end
    end

    // Counts data grants taken while fetch waits; loader grants and stall
    // cycles leave it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (!if_req || gnt[ID_IF])
            starve_cnt <= '0;
        else if (gnt[ID_D] && !starved)
            starve_cnt <= starve_cnt + SW'(1);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory among fetch, data and loader
// Ports: clk, rst (async active-low), bus (mem_port_arbiter_if.slave) carrying
//        the three requester ports, the memory strobe/address/data and busy.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDRSIZE   = DEF_ADDRSIZE,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WIDTH-1:0]    DATA_ZERO = '0;
    localparam logic [ADDRSIZE-1:0] ADDR_ZERO = '0;

    logic [0:0]    state;
    logic [LW-1:0] lat_cnt;
    port_id_t      owner;
    logic [2:0]    gnt;
    logic          arb_en;
    logic          rd_gnt;
    logic          lat_done;

    // Grants are masked while reset is held so every output reads 0.
    assign arb_en = rst && (state == ST_IDLE);

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
        .ld_req (bus.ld_req),
        .d_req  (bus.d_req),
        .if_req (bus.if_req),
        .gnt    (gnt)
    );

    assign bus.ld_gnt = gnt[ID_LD];
    assign bus.d_gnt  = gnt[ID_D];
    assign bus.if_gnt = gnt[ID_IF];
    assign bus.busy   = (state == ST_RD_WAIT);

    assign rd_gnt   = gnt[ID_IF] | (gnt[ID_D] & ~bus.d_we) | (gnt[ID_LD] & ~bus.ld_we);
    assign lat_done = (lat_cnt == LW'(RD_LAT - 1));

    // Fetch carries no write data, so the memory sees zero for it.
    always_comb begin
        bus.mem_en    = |gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = ADDR_ZERO;
        bus.mem_wdata = DATA_ZERO;
        if (gnt[ID_LD]) begin
            bus.mem_we    = bus.ld_we;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
        end else if (gnt[ID_D]) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (gnt[ID_IF]) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    // RD_WAIT spans the RD_LAT cycles after the read grant; mem_rdata is
    // valid in the last of them, so the next grant follows one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            owner   <= ID_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_gnt) begin
                        state   <= ST_RD_WAIT;
                        lat_cnt <= '0;
                        owner   <= gnt[ID_LD] ? ID_LD : (gnt[ID_D] ? ID_D : ID_IF);
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_done) begin
                        state   <= ST_IDLE;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.ld_rvalid <= 1'b0;
            bus.if_rdata  <= DATA_ZERO;
            bus.d_rdata   <= DATA_ZERO;
            bus.ld_rdata  <= DATA_ZERO;
        end else begin
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.ld_rvalid <= 1'b0;
            if (state == ST_RD_WAIT && lat_done) begin
                case (owner)
                    ID_LD: begin
                        bus.ld_rvalid <= 1'b1;
                        bus.ld_rdata  <= bus.mem_rdata;
                    end
                    ID_D: begin
                        bus.d_rvalid <= 1'b1;
                        bus.d_rdata  <= bus.mem_rdata;
                    end
                    ID_IF: begin
                        bus.if_rvalid <= 1'b1;
                        bus.if_rdata  <= bus.mem_rdata;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
